// File: rtl/gelato_types_pkg.sv
// Gelato shared types: ALU opcodes, data words and warp geometry.
package gelato_types;

  localparam int NUM_THREADS = 32;
  localparam int NUM_ALUS    = 8;
  localparam int DATA_WIDTH  = 32;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [NUM_THREADS*DATA_WIDTH-1:0] warp_reg_t;

  typedef enum logic [2:0] {
    ARITH_ADD,
    ARITH_SUB,
    ARITH_AND,
    ARITH_OR,
    ARITH_XOR,
    ARITH_MUL,
    ARITH_MADD
  } arith_oper_t;

  typedef enum logic [1:0] {
    DISP_IDLE,
    DISP_ISSUE,
    DISP_WAIT,
    DISP_DONE
  } disp_state_t;

endpackage

// File: rtl/gelato_alu_batch_collector.sv
// Tracks outstanding ALUs of the current batch and gathers
// their results into the warp-wide result buffer.
module gelato_alu_batch_collector
  import gelato_types::*;
#(
  parameter int LANES   = 8,
  parameter int WIDTH   = 32,
  parameter int THREADS = 32,
  parameter int BW      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     issue_i,
  input  logic [LANES-1:0]         issue_mask_i,
  input  logic                     sample_i,
  input  logic [BW-1:0]            batch_i,
  input  logic [LANES-1:0]         alu_done_i,
  input  logic [LANES*WIDTH-1:0]   alu_rd_i,
  output logic [THREADS*WIDTH-1:0] result_o,
  output logic                     retired_o
);

  logic [LANES-1:0]         pending_q, pending_d;
  logic [THREADS*WIDTH-1:0] result_q, result_d;

  always_comb begin
    pending_d = pending_q;
    result_d  = result_q;
    if (clear_i) begin
      pending_d = '0;
      result_d  = '0;
    end else if (issue_i) begin
      pending_d = issue_mask_i;
    end else if (sample_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (alu_done_i[i] && pending_q[i]) begin
          result_d[(int'(batch_i)*LANES + i)*WIDTH +: WIDTH] =
            alu_rd_i[i*WIDTH +: WIDTH];
          pending_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      result_q  <= '0;
    end else begin
      pending_q <= pending_d;
      result_q  <= result_d;
    end
  end

  // Retire in the same cycle the last outstanding result lands.
  assign retired_o = sample_i && ((pending_q & ~alu_done_i) == '0);
  assign result_o  = result_q;

endmodule

// File: rtl/gelato_alu_dispatcher.sv
// Splits a warp-wide compute task into NUM_ALUS-wide batches
// and issues them onto the shared ALU array.
module gelato_alu_dispatcher
  import gelato_types::*;
#(
  parameter int NUM_THREADS = gelato_types::NUM_THREADS,
  parameter int NUM_ALUS    = gelato_types::NUM_ALUS,
  parameter int DATA_WIDTH  = gelato_types::DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            task_valid,
  input  arith_oper_t                     task_op,
  input  logic [NUM_THREADS-1:0]          task_mask,
  input  logic [NUM_THREADS*DATA_WIDTH-1:0] task_rs1,
  input  logic [NUM_THREADS*DATA_WIDTH-1:0] task_rs2,
  input  logic [NUM_THREADS*DATA_WIDTH-1:0] task_rs3,
  output logic                            task_done,
  output logic [NUM_THREADS*DATA_WIDTH-1:0] task_rd,
  output logic [NUM_ALUS-1:0]             alu_valid,
  output arith_oper_t                     alu_op,
  output logic [NUM_ALUS*DATA_WIDTH-1:0]  alu_rs1,
  output logic [NUM_ALUS*DATA_WIDTH-1:0]  alu_rs2,
  output logic [NUM_ALUS*DATA_WIDTH-1:0]  alu_rs3,
  input  logic [NUM_ALUS-1:0]             alu_done,
  input  logic [NUM_ALUS*DATA_WIDTH-1:0]  alu_rd
);

  localparam int B  = NUM_THREADS / NUM_ALUS;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam int WW = NUM_THREADS * DATA_WIDTH;
  localparam int AW = NUM_ALUS * DATA_WIDTH;
  localparam logic [BW-1:0] LAST = BW'(B - 1);

  disp_state_t          state_q;
  logic [BW-1:0]        batch_q;
  arith_oper_t          op_q;
  logic [NUM_THREADS-1:0] mask_q;
  logic [WW-1:0]        rs1_q, rs2_q, rs3_q;
  logic [WW-1:0]        task_rd_q;
  logic [WW-1:0]        result;
  logic [NUM_ALUS-1:0]  batch_mask;
  logic                 retired;
  logic                 accept;
  logic                 issue;

  assign batch_mask = mask_q[int'(batch_q)*NUM_ALUS +: NUM_ALUS];
  assign accept     = (state_q == DISP_IDLE) && task_valid;
  assign issue      = (state_q == DISP_ISSUE) && (batch_mask != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DISP_IDLE;
      batch_q   <= '0;
      op_q      <= ARITH_ADD;
      mask_q    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rs3_q     <= '0;
      task_rd_q <= '0;
    end else begin
      unique case (state_q)
        DISP_IDLE: begin
          if (task_valid) begin
            op_q    <= task_op;
            mask_q  <= task_mask;
            rs1_q   <= task_rs1;
            rs2_q   <= task_rs2;
            rs3_q   <= task_rs3;
            batch_q <= '0;
            state_q <= DISP_ISSUE;
          end
        end
        DISP_ISSUE: begin
          if (batch_mask != '0) begin
            state_q <= DISP_WAIT;
          end else if (batch_q == LAST) begin
            state_q <= DISP_DONE;
          end else begin
            batch_q <= batch_q + 1'b1;
          end
        end
        DISP_WAIT: begin
          if (retired) begin
            if (batch_q == LAST) begin
              state_q <= DISP_DONE;
            end else begin
              batch_q <= batch_q + 1'b1;
              state_q <= DISP_ISSUE;
            end
          end
        end
        DISP_DONE: begin
          task_rd_q <= result;
          state_q   <= DISP_IDLE;
        end
        default: state_q <= DISP_IDLE;
      endcase
    end
  end

  gelato_alu_batch_collector #(
    .LANES   (NUM_ALUS),
    .WIDTH   (DATA_WIDTH),
    .THREADS (NUM_THREADS),
    .BW      (BW)
  ) u_collector (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (accept),
    .issue_i      (issue),
    .issue_mask_i (batch_mask),
    .sample_i     (state_q == DISP_WAIT),
    .batch_i      (batch_q),
    .alu_done_i   (alu_done),
    .alu_rd_i     (alu_rd),
    .result_o     (result),
    .retired_o    (retired)
  );

  // Operands stay on the bus until the batch retires.
  assign alu_valid = issue ? batch_mask : '0;
  assign alu_op    = op_q;
  assign alu_rs1   = rs1_q[int'(batch_q)*AW +: AW];
  assign alu_rs2   = rs2_q[int'(batch_q)*AW +: AW];
  assign alu_rs3   = rs3_q[int'(batch_q)*AW +: AW];
  assign task_done = (state_q == DISP_DONE);
  assign task_rd   = (state_q == DISP_DONE) ? result : task_rd_q;

endmodule

// File: tb/tb_gelato_alu_dispatcher.sv
// Directed + randomized bench for the ALU dispatcher with a
// behavioural ALU array and a per-thread warp result model.
module tb_gelato_alu_dispatcher;
  import gelato_types::*;

  localparam int NT = 32;
  localparam int NA = 8;
  localparam int DW = 32;
  localparam int B  = NT / NA;
  localparam int WW = NT * DW;
  localparam int AW = NA * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          task_valid;
  arith_oper_t   task_op;
  logic [NT-1:0] task_mask;
  logic [WW-1:0] task_rs1, task_rs2, task_rs3;
  logic          task_done;
  logic [WW-1:0] task_rd;
  logic [NA-1:0] alu_valid;
  arith_oper_t   alu_op;
  logic [AW-1:0] alu_rs1, alu_rs2, alu_rs3;
  logic [NA-1:0] alu_done;
  logic [AW-1:0] alu_rd;

  gelato_alu_dispatcher dut (
    .clk        (clk),
    .rst        (rst),
    .task_valid (task_valid),
    .task_op    (task_op),
    .task_mask  (task_mask),
    .task_rs1   (task_rs1),
    .task_rs2   (task_rs2),
    .task_rs3   (task_rs3),
    .task_done  (task_done),
    .task_rd    (task_rd),
    .alu_valid  (alu_valid),
    .alu_op     (alu_op),
    .alu_rs1    (alu_rs1),
    .alu_rs2    (alu_rs2),
    .alu_rs3    (alu_rs3),
    .alu_done   (alu_done),
    .alu_rd     (alu_rd)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int            lat [NA];
  int            cnt [NA];
  logic [DW-1:0] res [NA];
  bit            noise = 1'b0;
  int            issued = 0;

  logic [WW-1:0] exp_rd;
  int            exp_cyc;
  int            exp_issue;
  int            issue_base;

  function automatic logic [DW-1:0] alu_fn(input arith_oper_t op,
    input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    case (op)
      ARITH_ADD:  return a + b;
      ARITH_SUB:  return a - b;
      ARITH_AND:  return a & b;
      ARITH_OR:   return a | b;
      ARITH_XOR:  return a ^ b;
      ARITH_MUL:  return a * b;
      ARITH_MADD: return a * b + c;
      default:    return '0;
    endcase
  endfunction

  // Behavioural ALU array: fixed per-lane latency, optional
  // spurious done pulses on idle lanes.
  always @(negedge clk) begin
    for (int i = 0; i < NA; i++) begin
      alu_done[i] = 1'b0;
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          alu_done[i] = 1'b1;
          alu_rd[i*DW +: DW] = res[i];
        end
      end else if (noise && $urandom_range(0, 3) == 0) begin
        alu_done[i] = 1'b1;
        alu_rd[i*DW +: DW] = $urandom;
      end
      if (alu_valid[i]) begin
        res[i] = alu_fn(alu_op, alu_rs1[i*DW +: DW],
                        alu_rs2[i*DW +: DW], alu_rs3[i*DW +: DW]);
        cnt[i] = lat[i];
        issued++;
      end
    end
  end

  task automatic check(input string tag, input logic [WW-1:0] got,
                       input logic [WW-1:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic setup(input arith_oper_t op, input logic [NT-1:0] m,
                       input bit ramp);
    logic [DW-1:0] a, b, c;
    int lm;
    task_op   = op;
    task_mask = m;
    for (int t = 0; t < NT; t++) begin
      a = ramp ? DW'(t) : $urandom;
      b = ramp ? 32'd1 : $urandom;
      c = $urandom;
      task_rs1[t*DW +: DW] = a;
      task_rs2[t*DW +: DW] = b;
      task_rs3[t*DW +: DW] = c;
      exp_rd[t*DW +: DW] = m[t] ? alu_fn(op, a, b, c) : '0;
    end
    exp_issue  = $countones(m);
    issue_base = issued;
    exp_cyc = 1;
    for (int bt = 0; bt < B; bt++) begin
      lm = 0;
      for (int i = 0; i < NA; i++)
        if (m[bt*NA + i] && lat[i] > lm) lm = lat[i];
      exp_cyc += (lm == 0) ? 1 : lm + 1;
    end
  endtask

  task automatic wait_done(input string tag);
    int c;
    bit seen;
    c = 0;
    seen = 1'b0;
    while (!seen && c < 400) begin
      @(negedge clk);
      c++;
      seen = task_done;
    end
    check({tag, "_seen"}, WW'(seen), WW'(1));
    check({tag, "_cycle"}, WW'(c), WW'(exp_cyc));
    check({tag, "_rd"}, task_rd, exp_rd);
    check({tag, "_issues"}, WW'(issued - issue_base), WW'(exp_issue));
  endtask

  task automatic finish_task(input string tag);
    @(negedge clk);
    check({tag, "_pulse"}, WW'(task_done), WW'(0));
    check({tag, "_hold"}, task_rd, exp_rd);
  endtask

  task automatic run(input string tag);
    task_valid = 1'b1;
    wait_done(tag);
    task_valid = 1'b0;
    finish_task(tag);
  endtask

  logic [NT-1:0] m;
  int            n;
  int            c;

  initial begin
    rst        = 1'b1;
    task_valid = 1'b0;
    task_op    = ARITH_ADD;
    task_mask  = '0;
    task_rs1   = '0;
    task_rs2   = '0;
    task_rs3   = '0;
    for (int i = 0; i < NA; i++) lat[i] = 1;
    repeat (2) @(negedge clk);
    check("rst_done", WW'(task_done), WW'(0));
    check("rst_rd", task_rd, '0);
    check("rst_valid", WW'(alu_valid), WW'(0));
    check("rst_op", WW'(alu_op), WW'(0));
    check("rst_rs", WW'({alu_rs1, alu_rs2, alu_rs3}), '0);
    rst = 1'b0;

    setup(ARITH_ADD, '1, 1'b1);
    run("full_l1");

    setup(arith_oper_t'($urandom_range(0, 6)), 32'h0000_00FF, 1'b0);
    run("one_batch");

    setup(ARITH_MADD, '0, 1'b0);
    run("empty");

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NA; i++) lat[i] = $urandom_range(1, 4);
      noise = 1'($urandom_range(0, 1));
      m = $urandom;
      for (int bt = 0; bt < B; bt++)
        if ($urandom_range(0, 3) == 0) m[bt*NA +: NA] = '0;
      setup(arith_oper_t'($urandom_range(0, 6)), m, 1'b0);
      run($sformatf("rand%0d", k));
    end

    for (int i = 0; i < NA; i++) lat[i] = i + 1;
    noise = 1'b1;
    setup(ARITH_SUB, 32'hF0FF_7E81, 1'b0);
    run("ooo_spur");

    noise = 1'b0;
    for (int i = 0; i < NA; i++) lat[i] = 2;
    setup(ARITH_ADD, '1, 1'b0);
    task_valid = 1'b1;
    n = 0;
    c = 0;
    while (n < 3 && c < 100) begin
      @(negedge clk);
      c++;
      if (alu_valid != '0) n++;
    end
    task_valid = 1'b0;
    check("mid_reach", WW'(n), WW'(3));
    @(negedge clk);
    rst = 1'b1;
    noise = 1'b1;
    @(negedge clk);
    check("mid_done", WW'(task_done), WW'(0));
    check("mid_rd", task_rd, '0);
    check("mid_valid", WW'(alu_valid), WW'(0));
    check("mid_op", WW'(alu_op), WW'(0));
    check("mid_rs", WW'({alu_rs1, alu_rs2, alu_rs3}), '0);
    rst = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (task_done || alu_valid != '0) n++;
    end
    check("mid_quiet", WW'(n), WW'(0));
    check("mid_rd_idle", task_rd, '0);
    setup(ARITH_XOR, $urandom, 1'b0);
    run("post_rst");

    noise = 1'b0;
    for (int i = 0; i < NA; i++) lat[i] = $urandom_range(1, 3);
    setup(ARITH_MUL, $urandom, 1'b0);
    task_valid = 1'b1;
    wait_done("b2b_a");
    setup(ARITH_OR, $urandom, 1'b0);
    exp_cyc += 1;
    wait_done("b2b_b");
    task_valid = 1'b0;
    finish_task("b2b_b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
